// File: rtl/rr_hold_arbiter.sv
// ============================================================================
// Module      : rr_hold_arbiter
// Description : Round-robin arbiter with registered one-hot grants, grant
//               hold while the owner keeps requesting, and a bounded hold
//               limit. Optional high-priority class under RR_ARB_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic [N-1:0]    req,
`ifdef RR_ARB_PRIO_EN
    input  logic [N-1:0]    prio,
`endif
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx
);

    // Wide enough to hold MAX_HOLD; a single bit suffices when unlimited.
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0]      ONE_HOT0 = N'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [IDXW-1:0]     r_owner;
    logic [IDXW-1:0]     r_last;
    logic [HOLD_W-1:0]   r_hold;

    state_t              w_nxt_state;
    logic [IDXW-1:0]     w_nxt_owner;
    logic [IDXW-1:0]     w_nxt_last;
    logic [HOLD_W-1:0]   w_nxt_hold;
    logic [N-1:0]        w_nxt_grant;
    logic [IDXW-1:0]     w_nxt_idx;

    logic [N-1:0]        w_owner_mask;
    logic [N-1:0]        w_pool;
    logic [N-1:0]        w_cand;
    logic                w_found;
    logic [IDXW-1:0]     w_win;
    logic                w_owner_req;
    logic                w_expired;

    // The current owner is never a candidate: on drop it is not requesting,
    // and on hold expiry it must yield to anyone else waiting.
    always_comb begin
        w_owner_mask = '0;
        if (r_state == S_OWN) begin
            w_owner_mask = ONE_HOT0 << r_owner;
        end
        w_pool = req & ~w_owner_mask;
    end

`ifdef RR_ARB_PRIO_EN
    logic [N-1:0] w_hp;

    always_comb begin
        w_hp   = w_pool & prio;
        w_cand = (|w_hp) ? w_hp : w_pool;
    end
`else
    always_comb begin
        w_cand = w_pool;
    end
`endif

    // First set candidate bit scanning upward from last+1 with wrap-around.
    always_comb begin : p_search
        int              k;
        logic [IDXW-1:0] pos;
        k       = 0;
        pos     = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            k   = (int'(r_last) + 1 + i) % N;
            pos = IDXW'(k);
            if (!w_found && w_cand[pos]) begin
                w_found = 1'b1;
                w_win   = pos;
            end
        end
    end

    always_comb begin
        w_owner_req = req[r_owner];
        w_expired   = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_owner = r_owner;
        w_nxt_last  = r_last;
        w_nxt_hold  = r_hold;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt_state = S_OWN;
                    w_nxt_owner = w_win;
                    w_nxt_last  = w_win;
                    w_nxt_hold  = HOLD_ONE;
                end
            end

            S_OWN: begin
                if (w_owner_req && !w_expired) begin
                    if (r_hold != '1) begin
                        w_nxt_hold = r_hold + HOLD_ONE;
                    end
                end else if (w_found) begin
                    w_nxt_owner = w_win;
                    w_nxt_last  = w_win;
                    w_nxt_hold  = HOLD_ONE;
                end else if (w_owner_req) begin
                    // Expired but uncontested: re-grant in place, no dead cycle.
                    w_nxt_last  = r_owner;
                    w_nxt_hold  = HOLD_ONE;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_hold  = '0;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_hold  = '0;
            end
        endcase

        w_nxt_grant = '0;
        w_nxt_idx   = '0;
        if (w_nxt_state == S_OWN) begin
            w_nxt_grant = ONE_HOT0 << w_nxt_owner;
            w_nxt_idx   = w_nxt_owner;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_last      <= IDXW'(N - 1);
            r_hold      <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_owner     <= w_nxt_owner;
            r_last      <= w_nxt_last;
            r_hold      <= w_nxt_hold;
            grant       <= w_nxt_grant;
            grant_valid <= (w_nxt_state == S_OWN);
            grant_idx   <= w_nxt_idx;
        end
    end

endmodule

`default_nettype wire
